xbar_arbiter: RTL and testbench
===============================

# xbar_arbiter

Sequencing and arbitration controller for the 2-master x 2-slave crossbar. One independent FSM per slave port shares that slave between the two masters by round-robin. It drives the Switch_Matrix selects (sel0/sel1) and the slave-side request strobes, holds each grant until the slave acks or a timeout expires, and reports per-master completion and error.

## Interface
- TO_W, default 8: width of the per-slave timeout counter.
- TIMEOUT, default 255: number of BUSY cycles without ack before the transaction is aborted. 0 disables the timeout. Must be < 2^TO_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  master request, bit 65 of the master bus. The master holds it high until its done/err.
- m0_addr_msb, m1_addr_msb  in  1  address bit 31, bit 63 of the master bus. 0 = slave 0, 1 = slave 1. Stable while req is high.
- s0_ack, s1_ack  in  1  slave ack, bit 32 of the slave response.
- sel0  out  1  master currently routed to slave 0 (0 = m0, 1 = m1).
- sel1  out  1  master currently routed to slave 1.
- s0_req, s1_req  out  1  request strobe to the slave, high for the whole BUSY state.
- m0_gnt, m1_gnt  out  1  master owns some slave (level).
- m0_done, m1_done  out  1  single-cycle completion, combinational from the ack.
- m0_err, m1_err  out  1  single-cycle timeout abort, combinational.

## Operation
- Slave j sees master i as a requester when mi_req=1 and mi_addr_msb=j.
- Per-slave FSM states: IDLE, BUSY.
- **IDLE to BUSY:** taken at the edge where at least one requester exists.
  - Owner is the sole requester.
  - If both masters request, the owner is the master not recorded in last_j.
  - selj is set to the owner and the timeout counter is cleared to 0.
- **In BUSY:**
  - sj_req=1, and the owner's gnt=1.
  - The counter increments each cycle and saturates.
  - Requests to this slave from the other master are held off.
  - The owner dropping req mid-transaction is a protocol violation. It is ignored: the state stays BUSY until ack or timeout.
- **Ack:** when sj_ack=1 in BUSY, owner done=1 in the same cycle. Next edge: IDLE, and last_j is set to the owner.
- **Timeout:** when TIMEOUT≠0, counter = TIMEOUT-1 and sj_ack=0, owner err=1 in the same cycle. Next edge: IDLE, last_j is set to the owner, selj unchanged.
- **Ack and timeout in the same cycle:** ack wins; done=1, err=0.
- sj_ack while IDLE is ignored (no done, no state change).
- Both slaves may be BUSY simultaneously with different owners; there are no cross-slave conflicts. A master targets one slave at a time, so mi_gnt = OR of (BUSY_j and owner_j=i).
- selj holds its last value while IDLE, so the matrix stays connected.
- **Output gating:** m*_done and m*_err are gated by BUSY. sj_req is a registered state decode (no glitch).

## Timing
- Reset (reset=0, asynchronous):
  - Both FSMs go to IDLE; counters 0; last_0 = last_1 = 1, so m0 wins the first tie.
  - sel0=sel1=0, s*_req=0, m*_gnt=0, m*_done=0, m*_err=0 immediately.
  - Reset asserted mid-transaction aborts it silently (no done/err).
- Grant latency: requester present in cycle 0 → BUSY, selj, sj_req and gnt valid in cycle 1.
- Completion: ack in cycle k (k≥1) → done in cycle k; sj_req=0 and gnt=0 in cycle k+1.
- The master must deassert req by cycle k+1, or its still-high req is arbitrated as a new transaction in that IDLE cycle.
- Back-to-back on one slave: at least one IDLE cycle between transactions. Peak throughput is one transaction per 2 cycles with a 1-cycle slave.
- Timeout: err in BUSY cycle TIMEOUT (counter counts 0..TIMEOUT-1); IDLE the cycle after.

## Test plan
- **Single grant:** from reset, m0_req=1, m0_addr_msb=1 at cycle 0 → sel1=0, s1_req=1, m0_gnt=1 at cycle 1. s1_ack at cycle 3 → m0_done=1 at cycle 3; s1_req=0 at cycle 4.
- **Tie and round-robin:** both masters continuously target slave 0, slave acks 1 cycle after s0_req rises → grant order m0, m1, m0, m1. sel0 toggles; one IDLE cycle between each.
- **Parallel:** m0→slave 1 and m1→slave 0 requested together at cycle 0 → sel0=1, sel1=0, s0_req=s1_req=1, m0_gnt=m1_gnt=1 at cycle 1. Acks complete independently.
- **Timeout:** TIMEOUT=4, m1→slave 1, no ack → m1_err=1 in BUSY cycle 4, IDLE next cycle, last_1=1. With ack and timeout in the same cycle, m1_done=1 and m1_err=0.
- **Reset mid-operation:** reset driven low in BUSY cycle 2 → all outputs 0 asynchronously, no done/err. After release, m0 wins the first tie.
- **Protocol edges:** s0_ack while IDLE → no output change. Owner drops req while BUSY → s*_req stays 1 until ack.

Source files
------------

// File: rtl/xbar_arbiter.sv
// Per-slave round-robin arbiter for a 2x2 crossbar: drives switch selects,
// slave request strobes, and per-master grant/done/timeout-error.
module xbar_arbiter #(
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic m0_req,
   input  logic m1_req,
   input  logic m0_addr_msb,
   input  logic m1_addr_msb,
   input  logic s0_ack,
   input  logic s1_ack,
   output logic sel0,
   output logic sel1,
   output logic s0_req,
   output logic s1_req,
   output logic m0_gnt,
   output logic m1_gnt,
   output logic m0_done,
   output logic m1_done,
   output logic m0_err,
   output logic m1_err
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic            TO_ON   = (TIMEOUT != 0);

   logic [1:0]           busy, sel, last;
   logic [1:0][TO_W-1:0] cnt;
   logic [1:0]           sack, done, err;

   assign sack = {s1_ack, s0_ack};

   for (genvar j = 0; j < 2; j++) begin : g_slv
      logic [1:0]      rq;
      logic            hit;
      logic            nbusy, nsel, nlast;
      logic [TO_W-1:0] ncnt;

      assign rq[0] = m0_req & (m0_addr_msb == 1'(j));
      assign rq[1] = m1_req & (m1_addr_msb == 1'(j));
      assign hit   = TO_ON & (cnt[j] == TO_LAST);

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            busy[j] <= 1'b0;
            sel[j]  <= 1'b0;
            last[j] <= 1'b1;
            cnt[j]  <= '0;
         end else begin
            busy[j] <= nbusy;
            sel[j]  <= nsel;
            last[j] <= nlast;
            cnt[j]  <= ncnt;
         end
      end

      always_comb begin
         nbusy = busy[j];
         nsel  = sel[j];
         nlast = last[j];
         ncnt  = cnt[j];
         unique case (1'b1)
            !busy[j]: begin
               if (|rq) begin
                  nbusy = 1'b1;
                  ncnt  = '0;
                  // On a tie the master that did not win last time goes next
                  nsel  = (rq == 2'b11) ? ~last[j] : rq[1];
               end
            end
            busy[j]: begin
               if (sack[j] | hit) begin
                  nbusy = 1'b0;
                  nlast = sel[j];
               end else if (cnt[j] != '1) begin
                  ncnt = cnt[j] + 1'b1;
               end
            end
         endcase
      end

      always_comb begin
         done[j] = busy[j] & sack[j];
         err[j]  = busy[j] & hit & ~sack[j];
      end
   end

   assign sel0   = sel[0];
   assign sel1   = sel[1];
   assign s0_req = busy[0];
   assign s1_req = busy[1];

   assign m0_gnt  = (busy[0] & ~sel[0]) | (busy[1] & ~sel[1]);
   assign m1_gnt  = (busy[0] &  sel[0]) | (busy[1] &  sel[1]);
   assign m0_done = (done[0] & ~sel[0]) | (done[1] & ~sel[1]);
   assign m1_done = (done[0] &  sel[0]) | (done[1] &  sel[1]);
   assign m0_err  = (err[0]  & ~sel[0]) | (err[1]  & ~sel[1]);
   assign m1_err  = (err[0]  &  sel[0]) | (err[1]  &  sel[1]);

endmodule

// File: tb/tb_xbar_arbiter.sv
// Directed bench for xbar_arbiter: grant, round-robin, parallel,
// timeout, async reset and protocol-edge scenarios.
module tb_xbar_arbiter;

   logic clk = 1'b0;
   logic reset;
   logic m0_req, m1_req, m0_addr_msb, m1_addr_msb;
   logic s0_ack, s1_ack;
   logic sel0, sel1, s0_req, s1_req;
   logic m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   xbar_arbiter #(.TO_W(8), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m1_req(m1_req),
      .m0_addr_msb(m0_addr_msb), .m1_addr_msb(m1_addr_msb),
      .s0_ack(s0_ack), .s1_ack(s1_ack),
      .sel0(sel0), .sel1(sel1),
      .s0_req(s0_req), .s1_req(s1_req),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
      .m0_done(m0_done), .m1_done(m1_done),
      .m0_err(m0_err), .m1_err(m1_err)
   );

   task automatic chk(input string tag, input logic [9:0] obs,
                      input logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Moves into the next cycle, away from the clock edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // {sel0,sel1,s0_req,s1_req,m0_gnt,m1_gnt,m0_done,m1_done,m0_err,m1_err}
   function automatic logic [9:0] outs();
      return {sel0, sel1, s0_req, s1_req, m0_gnt, m1_gnt,
              m0_done, m1_done, m0_err, m1_err};
   endfunction

   initial begin
      reset = 1'b0;
      m0_req = 0; m1_req = 0; m0_addr_msb = 0; m1_addr_msb = 0;
      s0_ack = 0; s1_ack = 0;
      #12;
      chk("reset_outs", outs(), 10'b0);
      reset = 1'b1;
      tick();

      // Single grant: m0 -> slave 1
      m0_req = 1; m0_addr_msb = 1;
      tick();
      chk("sg_c1", outs(), 10'b0001100000);
      tick();
      tick();
      s1_ack = 1;
      #1;
      chk("sg_done", outs(), 10'b0001101000);
      m0_req = 0;
      tick();
      s1_ack = 0;
      #1;
      chk("sg_c4", outs(), 10'b0);

      // Round-robin on slave 0 with both masters continuously requesting
      m0_req = 1; m0_addr_msb = 0;
      m1_req = 1; m1_addr_msb = 0;
      for (int k = 0; k < 4; k++) begin
         logic o;
         o = k[0];
         tick();
         chk($sformatf("rr_gnt%0d", k), {sel0, s0_req, m0_gnt, m1_gnt},
             {o, 1'b1, ~o, o});
         tick();
         s0_ack = 1;
         #1;
         chk($sformatf("rr_done%0d", k), {m0_done, m1_done}, {~o, o});
         tick();
         s0_ack = 0;
         #1;
         chk($sformatf("rr_idle%0d", k), {sel0, s0_req, m0_gnt, m1_gnt},
             {o, 3'b000});
      end
      m0_req = 0; m1_req = 0;
      tick();

      // Parallel: m0 -> slave 1, m1 -> slave 0
      m0_req = 1; m0_addr_msb = 1;
      m1_req = 1; m1_addr_msb = 0;
      tick();
      chk("par_c1", outs(), 10'b1011110000);
      tick();
      s0_ack = 1;
      #1;
      chk("par_ack0", outs(), 10'b1011110100);
      m1_req = 0;
      tick();
      s0_ack = 0; s1_ack = 1;
      #1;
      chk("par_ack1", outs(), 10'b1001101000);
      m0_req = 0;
      tick();
      s1_ack = 0;
      #1;
      chk("par_idle", outs(), 10'b1000000000);

      // Timeout: m1 -> slave 1, no ack
      m1_req = 1; m1_addr_msb = 1;
      tick();
      chk("to_c1", outs(), 10'b1101010000);
      tick();
      tick();
      chk("to_c3", {m1_done, m1_err}, 2'b00);
      tick();
      chk("to_c4", outs(), 10'b1101010001);
      m1_req = 0;
      tick();
      chk("to_idle", outs(), 10'b1100000000);

      // Tie on slave 1 after timeout: last_1 = m1, so m0 wins
      m0_req = 1; m0_addr_msb = 1;
      m1_req = 1; m1_addr_msb = 1;
      tick();
      chk("to_tie", outs(), 10'b1001100000);
      s1_ack = 1;
      #1;
      chk("to_tie_done", {m0_done, m1_done}, 2'b10);
      m0_req = 0;
      tick();
      s1_ack = 0;
      #1;
      chk("to_tie_idle", {s1_req, m0_gnt, m1_gnt}, 3'b000);
      tick();
      chk("tb_m1_gnt", {sel1, s1_req, m1_gnt}, 3'b111);
      tick();
      tick();
      tick();
      s1_ack = 1;
      #1;
      chk("ack_vs_to", {m1_done, m1_err}, 2'b10);
      m1_req = 0;
      tick();
      s1_ack = 0;
      #1;
      chk("ack_vs_to_idle", {s1_req, m1_gnt, m1_err}, 3'b000);

      // Reset mid-transaction on slave 0
      m0_req = 1; m0_addr_msb = 0;
      tick();
      tick();
      chk("rst_busy", {s0_req, m0_gnt}, 2'b11);
      reset = 1'b0;
      s0_ack = 1;
      #1;
      chk("rst_async", outs(), 10'b0);
      s0_ack = 0;
      m1_req = 1; m1_addr_msb = 0;
      #1;
      reset = 1'b1;
      tick();
      chk("rst_tie", outs(), 10'b0010100000);
      s0_ack = 1;
      m0_req = 0; m1_req = 0;
      #1;
      chk("rst_tie_done", {m0_done, m1_done}, 2'b10);
      tick();
      s0_ack = 0;

      // Protocol edges: ack while idle, owner dropping req
      s0_ack = 1;
      #1;
      chk("idle_ack", outs(), 10'b0);
      tick();
      s0_ack = 0;
      #1;
      chk("idle_ack_next", outs(), 10'b0);
      m1_req = 1; m1_addr_msb = 0;
      tick();
      m1_req = 0;
      tick();
      chk("drop_req", {sel0, s0_req, m1_gnt}, 3'b111);
      tick();
      s0_ack = 1;
      #1;
      chk("drop_req_done", {s0_req, m1_done, m1_err}, 3'b110);
      tick();
      s0_ack = 0;
      #1;
      chk("drop_req_idle", {s0_req, m1_gnt}, 2'b00);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
